// File: rtl/ram_read_streamer_pkg.sv
// ============================================================================
// Module   : ram_stream_pkg
// Brief    : Shared types and constants for the RAM read streamer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam int DEF_MW     = 8;
  localparam int DEF_DW     = 8;
  localparam int DEF_WORD_W = DEF_MW * DEF_DW;

  function automatic int word_width(input int mw, input int dw);
    return mw * dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_read_streamer_if.sv
// ============================================================================
// Module   : ram_read_streamer_if
// Brief    : Control, RAM-port and output-stream bundle of the read streamer.
//            RAM_READ_STREAMER_LAST_EN adds the out_last stream flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_read_streamer_if #(
  parameter int AW = 11,
  parameter int MW = 8,
  parameter int DW = 8,
  parameter int CW = 12
);

  logic             start;
  logic [AW-1:0]    base_addr;
  logic [CW-1:0]    num_words;
  logic [AW-1:0]    stride;
  logic [AW-1:0]    ram_addr;
  logic [MW-1:0]    ram_we;
  logic [MW*DW-1:0] ram_d;
  logic [MW*DW-1:0] ram_q;
  logic [MW*DW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
`ifdef RAM_READ_STREAMER_LAST_EN
  logic             out_last;
`endif

  modport master (
    input  start, base_addr, num_words, stride, ram_q, out_ready,
    output ram_addr, ram_we, ram_d, out_data, out_valid, busy, done
`ifdef RAM_READ_STREAMER_LAST_EN
    , output out_last
`endif
  );

  modport slave (
    output start, base_addr, num_words, stride, ram_q, out_ready,
    input  ram_addr, ram_we, ram_d, out_data, out_valid, busy, done
`ifdef RAM_READ_STREAMER_LAST_EN
    , input out_last
`endif
  );

endinterface

`default_nettype wire

// File: rtl/ram_read_streamer_skid_fifo.sv
// ============================================================================
// Module   : stream_skid_fifo
// Brief    : Two-entry FIFO, head register drives the output directly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_fifo
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [FIFO_CNT_W-1:0] count_o
);

  logic [WIDTH-1:0]      head_q;
  logic [WIDTH-1:0]      tail_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  pop;

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = head_q;
  assign count_o     = count_q;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      unique case ({in_valid_i, pop})
        2'b10: begin
          if (count_q == '0) head_q <= in_data_i;
          else               tail_q <= in_data_i;
          count_q <= count_q + FIFO_CNT_W'(1);
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - FIFO_CNT_W'(1);
        end
        2'b11: begin
          // Occupancy is unchanged; only the entry order shifts.
          if (count_q == FIFO_CNT_W'(1)) begin
            head_q <= in_data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= in_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_read_streamer.sv
// ============================================================================
// Module   : ram_read_streamer
// Brief    : Walks base/count/stride over a 1-cycle-latency RAM and streams
//            the words out. RAM_READ_STREAMER_LAST_EN adds out_last.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_read_streamer
  import ram_stream_pkg::*;
#(
  parameter int AW = 11,
  parameter int MW = 8,
  parameter int DW = 8,
  parameter int CW = 12
) (
  input  logic                 clk,
  input  logic                 resetn,
  ram_read_streamer_if.master  bus
);

  localparam int WW = word_width(MW, DW);
`ifdef RAM_READ_STREAMER_LAST_EN
  localparam int FW = WW + 1;
`else
  localparam int FW = WW;
`endif
  localparam int OW = FIFO_CNT_W + 1;

  state_t                state_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         stride_q;
  logic [CW-1:0]         num_q;
  logic [CW-1:0]         issued_q;
  logic                  rd_pending_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef RAM_READ_STREAMER_LAST_EN
  logic                  last_pending_q;
`endif

  logic [FW-1:0]         fifo_in;
  logic [FW-1:0]         fifo_out;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_valid;
  logic                  pop;
  logic [OW-1:0]         occupancy;
  logic                  issue;
  logic                  issue_last;
  logic                  drain_empty;

  assign pop       = fifo_valid & bus.out_ready;
  // Words held or in flight once this cycle's pop is accounted for.
  assign occupancy = {1'b0, fifo_count} + OW'(rd_pending_q) - OW'(pop);
  assign issue       = (state_q == RUN) && (issued_q != num_q) && (occupancy < OW'(FIFO_DEPTH));
  assign issue_last  = (issued_q + CW'(1)) == num_q;
  assign drain_empty = !rd_pending_q && ((fifo_count - FIFO_CNT_W'(pop)) == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      num_q        <= '0;
      issued_q     <= '0;
      rd_pending_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef RAM_READ_STREAMER_LAST_EN
      last_pending_q <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      rd_pending_q <= issue;
`ifdef RAM_READ_STREAMER_LAST_EN
      last_pending_q <= issue && issue_last;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            num_q    <= bus.num_words;
            stride_q <= bus.stride;
            issued_q <= '0;
            if (bus.num_words == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= bus.base_addr;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q   <= addr_q + stride_q;
            issued_q <= issued_q + CW'(1);
            if (issue_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RAM_READ_STREAMER_LAST_EN
  assign fifo_in      = {last_pending_q, bus.ram_q};
  assign bus.out_last = fifo_out[WW];
`else
  assign fifo_in      = bus.ram_q;
`endif

  stream_skid_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (resetn),
    .in_valid_i  (rd_pending_q),
    .in_data_i   (fifo_in),
    .out_valid_o (fifo_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (fifo_out),
    .count_o     (fifo_count)
  );

  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = '0;
  assign bus.ram_d     = '0;
  assign bus.out_data  = fifo_out[WW-1:0];
  assign bus.out_valid = fifo_valid;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_read_streamer.sv
// ============================================================================
// Module   : tb_ram_read_streamer
// Brief    : Scoreboard bench for ram_read_streamer with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_read_streamer;

  localparam int AW = 11;
  localparam int MW = 8;
  localparam int DW = 8;
  localparam int CW = 12;
  localparam int WW = MW * DW;
  localparam int DEPTH = 1 << AW;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ram_read_streamer_if #(.AW(AW), .MW(MW), .DW(DW), .CW(CW)) bus ();

  ram_read_streamer #(.AW(AW), .MW(MW), .DW(DW), .CW(CW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [WW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endfunction

  function automatic void chk_word(input string name, input logic [WW:0] got, input logic [WW:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endfunction

  // Expected entries are {last, data}.
  logic [WW:0] exp_q [$];
  logic [WW:0] mon_e;
  logic [WW:0] mon_got;
  int  first_valid = -1;
  int  last_hs     = -1;
  int  hs_cnt      = 0;
  int  done_cnt    = 0;
  int  done_cyc    = -1;
  bit  stalled_prev = 1'b0;
  logic [WW-1:0] prev_data;

  int ready_mode = 0;
  int rstep      = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = pat[rstep % 6];
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    rstep++;
  end

  always @(negedge clk) begin
    if (!resetn) begin
      stalled_prev = 1'b0;
    end else begin
      chk_word("ram_we_ram_d_zero", {1'b0, bus.ram_d | {{(WW-MW){1'b0}}, bus.ram_we}}, '0);
      chk_int("fifo_count_max", int'(dut.u_fifo.count_o <= 2), 1);
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (stalled_prev) begin
        chk_int("stall_valid_held", int'(bus.out_valid), 1);
        chk_word("stall_data_held", {1'b0, bus.out_data}, {1'b0, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
`ifdef RAM_READ_STREAMER_LAST_EN
        mon_got = {bus.out_last, bus.out_data};
`else
        mon_got = {1'b0, bus.out_data};
`endif
        if (exp_q.size() == 0) begin
          chk_word("unexpected_word", mon_got, '1);
        end else begin
          mon_e = exp_q.pop_front();
`ifndef RAM_READ_STREAMER_LAST_EN
          mon_e[WW] = 1'b0;
`endif
          chk_word("stream_word", mon_got, mon_e);
        end
        hs_cnt++;
        last_hs = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_data    = bus.out_data;
    end
  end

  task automatic run(input int base, input int num, input int strd, input int mode, input bit poke);
    int t0;
    int d0;
    logic [AW-1:0] addr_before;
    ready_mode = mode;
    rstep      = 0;
    for (int i = 0; i < num; i++)
      exp_q.push_back({(i == num - 1), mem[(base + i * strd) % DEPTH]});
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.num_words = CW'(num);
    bus.stride    = AW'(strd);
    t0          = cyc;
    d0          = done_cnt;
    first_valid = -1;
    hs_cnt      = 0;
    addr_before = bus.ram_addr;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.base_addr = AW'($urandom);
      bus.num_words = CW'(5);
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    for (int k = 0; k < 4000 && done_cnt == d0; k++) @(posedge clk);
    chk_int("done_seen", int'(done_cnt != d0), 1);
    if (num == 0) begin
      chk_int("zero_done_latency", done_cyc, t0 + 1);
      chk_int("zero_addr_unchanged", int'(bus.ram_addr), int'(addr_before));
    end else begin
      chk_int("first_valid_latency", first_valid, t0 + 3);
      chk_int("done_after_last_hs", done_cyc, last_hs + 1);
      chk_int("handshake_count", hs_cnt, num);
      if (mode == 0) chk_int("full_throughput", last_hs, t0 + 3 + num - 1);
    end
    chk_int("scoreboard_empty", exp_q.size(), 0);
    @(negedge clk);
    chk_int("busy_low_after", int'(bus.busy), 0);
    exp_q.delete();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.stride    = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (i < 16) ? WW'(i) : {$urandom, $urandom};

    #1;
    chk_word("reset_outputs",
             {1'b0, bus.out_data | WW'(bus.ram_addr)},
             '0);
    chk_int("reset_flags", int'({bus.out_valid, bus.busy, bus.done}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    run(4, 8, 1, 0, 1'b0);
    run(2040, 4, 5, 0, 1'b0);
    run(256, 6, 1, 1, 1'b0);
    run(100, 0, 3, 0, 1'b0);
    run(300, 10, 2, 0, 1'b1);
    run(50, 3, 7, 2, 1'b0);
    run(777, 1, 1, 0, 1'b0);

    // Reset mid-transfer, then restart.
    begin
      int d0;
      ready_mode = 0;
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), mem[(16 + i * 3) % DEPTH]});
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_addr = AW'(16); bus.num_words = CW'(8); bus.stride = AW'(3);
      hs_cnt = 0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 200 && hs_cnt < 3; k++) @(negedge clk);
      chk_int("reached_three_words", int'(hs_cnt >= 3), 1);
      d0 = done_cnt;
      @(posedge clk); #3;
      resetn = 1'b0;
      #1;
      chk_word("async_reset_outputs", {1'b0, bus.out_data | WW'(bus.ram_addr)}, '0);
      chk_int("async_reset_flags", int'({bus.out_valid, bus.busy, bus.done}), 0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      chk_int("no_done_after_reset", done_cnt, d0);
    end
    run(0, 2, 1, 0, 1'b0);

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)),
          int'($urandom_range(0, DEPTH - 1)), 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
